// File: rtl/pwm_capture.sv
// pwm_capture: input-capture peripheral measuring the active-phase width and
// full period of an external pulse in prescaled ticks, with a small register
// window on the shared data bus and an active-low interrupt.
module pwm_capture #(
  parameter logic [31:0] base_address = 32'h40C0,
  parameter int          CNT_W        = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data_bus_write,
  output logic [31:0] data_bus_read,
  input  logic [31:0] data_bus_addr,
  input  logic [1:0]  data_bus_mode,
  input  logic        data_bus_select,
  input  logic        capture_in,
  output logic        capture_irq
);

  localparam logic [31:0] OFF_CNTRL   = 32'h00;
  localparam logic [31:0] OFF_PRSCLR  = 32'h04;
  localparam logic [31:0] OFF_HIGH    = 32'h08;
  localparam logic [31:0] OFF_PERIOD  = 32'h0C;
  localparam logic [31:0] OFF_STATUS  = 32'h10;
  localparam logic [31:0] OFF_TIMEOUT = 32'h14;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_HIGH,
    ST_LOW
  } state_t;

  // Input path flops
  logic [1:0]       sync_q, sync_d;
  logic             prev_q, prev_d;

  // Control / configuration registers
  logic             enable_q, enable_d;
  logic             irq_en_q, irq_en_d;
  logic             invert_q, invert_d;
  logic [CNT_W-1:0] prsclr_th_q, prsclr_th_d;
  logic [CNT_W-1:0] timeout_th_q, timeout_th_d;

  // Measurement state
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] presc_q, presc_d;
  logic [CNT_W-1:0] high_tmp_q, high_tmp_d;
  logic [CNT_W-1:0] high_cap_q, high_cap_d;
  logic [CNT_W-1:0] period_cap_q, period_cap_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             timeout_q, timeout_d;

  // Combinational helpers
  logic [31:0]      addr_off;
  logic             wr_en;
  logic             wr_cntrl, wr_prsclr, wr_status, wr_timeout;
  logic             sig, rise, fall;
  logic             tick;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] presc_next;
  logic             timeout_hit;
  logic             cap_set, to_set;

  assign addr_off   = data_bus_addr - base_address;
  assign wr_en      = data_bus_select && (data_bus_mode == 2'b10);
  assign wr_cntrl   = wr_en && (addr_off == OFF_CNTRL);
  assign wr_prsclr  = wr_en && (addr_off == OFF_PRSCLR);
  assign wr_status  = wr_en && (addr_off == OFF_STATUS);
  assign wr_timeout = wr_en && (addr_off == OFF_TIMEOUT);

  // Polarity-corrected input and edge detection against the registered copy.
  assign sig  = sync_q[1] ^ invert_q;
  assign rise = sig & ~prev_q;
  assign fall = ~sig & prev_q;

  // Prescaler fires a tick when it reaches the threshold; counter saturates.
  assign tick        = (presc_q >= prsclr_th_q);
  assign presc_next  = tick ? '0 : presc_q + 1'b1;
  assign cnt_next    = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(tick);
  assign timeout_hit = (timeout_th_q != '0) && (cnt_next >= timeout_th_q) && !(rise || fall);

  assign capture_irq = !(enable_q && irq_en_q && (valid_q || timeout_q));

  // Synchroniser shift and edge reference; a CNTRL write re-seeds the
  // reference with the new polarity so an invert change is not seen as an edge.
  always_comb begin
    sync_d = {sync_q[0], capture_in};
    prev_d = wr_cntrl ? (sync_q[1] ^ data_bus_write[2]) : sig;
  end

  // Configuration register writes.
  always_comb begin
    enable_d     = wr_cntrl   ? data_bus_write[0] : enable_q;
    irq_en_d     = wr_cntrl   ? data_bus_write[1] : irq_en_q;
    invert_d     = wr_cntrl   ? data_bus_write[2] : invert_q;
    prsclr_th_d  = wr_prsclr  ? data_bus_write[CNT_W-1:0] : prsclr_th_q;
    timeout_th_d = wr_timeout ? data_bus_write[CNT_W-1:0] : timeout_th_q;
  end

  // Measurement FSM: next state, counters and capture loads.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_next;
    presc_d      = presc_next;
    high_tmp_d   = high_tmp_q;
    high_cap_d   = high_cap_q;
    period_cap_d = period_cap_q;
    cap_set      = 1'b0;
    to_set       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d   = '0;
        presc_d = '0;
      end
      ST_ARM: begin
        if (rise) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
          presc_d = '0;
        end
      end
      ST_HIGH: begin
        if (fall) begin
          state_d    = ST_LOW;
          high_tmp_d = cnt_next;
        end else if (timeout_hit) begin
          state_d = ST_ARM;
          to_set  = 1'b1;
          cnt_d   = '0;
          presc_d = '0;
        end
      end
      ST_LOW: begin
        if (rise) begin
          state_d      = ST_HIGH;
          period_cap_d = cnt_next;
          high_cap_d   = high_tmp_q;
          cap_set      = 1'b1;
          cnt_d        = '0;
          presc_d      = '0;
        end else if (timeout_hit) begin
          state_d = ST_ARM;
          to_set  = 1'b1;
          cnt_d   = '0;
          presc_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        presc_d = '0;
      end
    endcase

    // A control write restarts the measurement but keeps captures and flags.
    if (wr_cntrl) begin
      state_d      = data_bus_write[0] ? ST_ARM : ST_IDLE;
      cnt_d        = '0;
      presc_d      = '0;
      high_tmp_d   = '0;
      high_cap_d   = high_cap_q;
      period_cap_d = period_cap_q;
      cap_set      = 1'b0;
      to_set       = 1'b0;
    end
  end

  // Write-one-to-clear flags; a hardware set in the same cycle wins.
  always_comb begin
    valid_d   = (valid_q   && !(wr_status && data_bus_write[0])) || cap_set;
    overrun_d = (overrun_q && !(wr_status && data_bus_write[1])) || (cap_set && valid_q);
    timeout_d = (timeout_q && !(wr_status && data_bus_write[2])) || to_set;
  end

  // Register read mux, purely from the address.
  always_comb begin
    data_bus_read = '0;
    case (addr_off)
      OFF_CNTRL:   data_bus_read = {29'd0, invert_q, irq_en_q, enable_q};
      OFF_PRSCLR:  data_bus_read = prsclr_th_q;
      OFF_HIGH:    data_bus_read = high_cap_q;
      OFF_PERIOD:  data_bus_read = period_cap_q;
      OFF_STATUS:  data_bus_read = {29'd0, timeout_q, overrun_q, valid_q};
      OFF_TIMEOUT: data_bus_read = timeout_th_q;
      default:     data_bus_read = '0;
    endcase
  end

  // Input synchroniser and edge reference register.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  // Configuration, FSM, counters, captures and status.
  always_ff @(posedge clk) begin
    if (reset) begin
      enable_q     <= 1'b0;
      irq_en_q     <= 1'b0;
      invert_q     <= 1'b0;
      prsclr_th_q  <= '0;
      timeout_th_q <= '0;
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      presc_q      <= '0;
      high_tmp_q   <= '0;
      high_cap_q   <= '0;
      period_cap_q <= '0;
      valid_q      <= 1'b0;
      overrun_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      enable_q     <= enable_d;
      irq_en_q     <= irq_en_d;
      invert_q     <= invert_d;
      prsclr_th_q  <= prsclr_th_d;
      timeout_th_q <= timeout_th_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      presc_q      <= presc_d;
      high_tmp_q   <= high_tmp_d;
      high_cap_q   <= high_cap_d;
      period_cap_q <= period_cap_d;
      valid_q      <= valid_d;
      overrun_q    <= overrun_d;
      timeout_q    <= timeout_d;
    end
  end

endmodule
